// File: rtl/reg_load_arb.sv
// Round-robin write arbiter: grants one requester per clock onto a shared
// register-bank load bus with a registered one-hot load strobe.
module reg_load_arb #(
  parameter int unsigned W    = 8,
  parameter int unsigned NREQ = 4,
  parameter int unsigned NREG = 4,
  parameter int unsigned AW   = 2
) (
  input  logic              ck,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREG-1:0]   ld,
  output logic [W-1:0]      ld_data,
  output logic              err,
  output logic              busy
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_nxt;
  logic [PW-1:0]   win;
  logic [PW-1:0]   cand;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] gnt_nxt;
  logic [NREG-1:0] ld_nxt;
  logic [AW-1:0]   win_addr;
  logic [W-1:0]    win_data;
  logic            any;
  logic            err_nxt;

  always_comb begin
    // The requester acknowledged this cycle sits out, so a held req is never served twice.
    elig     = req & ~gnt;
    any      = 1'b0;
    win      = '0;
    cand     = '0;
    win_addr = '0;
    win_data = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = PW'((32'(ptr) + k) % NREQ);
      if (!any && elig[cand]) begin
        any = 1'b1;
        win = cand;
      end
    end
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (win == PW'(k)) begin
        win_addr = req_addr[k*AW +: AW];
        win_data = req_data[k*W +: W];
      end
    end
    gnt_nxt = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      gnt_nxt[k] = any && (win == PW'(k));
    end
    ld_nxt = '0;
    for (int unsigned k = 0; k < NREG; k++) begin
      ld_nxt[k] = any && (32'(win_addr) == k);
    end
    err_nxt = any && (32'(win_addr) >= NREG);
    ptr_nxt = any ? PW'((32'(win) + 1) % NREQ) : ptr;
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      gnt     <= '0;
      ld      <= '0;
      ld_data <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
      ptr     <= '0;
    end else begin
      gnt  <= gnt_nxt;
      ld   <= ld_nxt;
      err  <= err_nxt;
      busy <= any;
      ptr  <= ptr_nxt;
      if (any) ld_data <= win_data;
    end
  end

endmodule

// File: doc/reg_load_arb.md
# reg_load_arb

Round-robin write arbiter that shares a bank of NREG load-enabled N-bit registers among NREQ requesters. Each requester presents a target register index and a data word; the arbiter grants at most one request per clock and drives a registered one-hot load strobe plus a shared data bus into the register bank. It sits between the requesting datapath units and the regN instances, so that no two units load the bank in the same cycle.

## Interface
- `W`, default 8: data width; equals the width of each target regN.
- `NREQ`, default 4: number of requesters, 2..8.
- `NREG`, default 4: number of target registers, 1..16.
- `AW`, default 2: index width per requester; must satisfy 2^AW >= NREG.
- `ck`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  NREQ: level request per requester, held high until that requester's `gnt` is seen.
- `req_addr`  in  NREQ*AW: target index; requester i occupies bits [i*AW +: AW].
- `req_data`  in  NREQ*W: write data; requester i occupies bits [i*W +: W].
- `gnt`  out  NREQ: one-hot, single-cycle acknowledge to the served requester.
- `ld`  out  NREG: one-hot, single-cycle load enable, bit k drives `l` of register k.
- `ld_data`  out  W: data bus to all target registers.
- `err`  out  1: single-cycle pulse when the granted index is >= NREG.
- `busy`  out  1: registered; high while any eligible request is pending.

## Operation
- Eligible set E = `req` & ~`gnt`. The requester acknowledged this cycle is excluded from this cycle's arbitration, so a requester still holding `req` in the cycle of its `gnt` is never served twice.
- Round-robin pointer `ptr`, range 0..NREQ-1. The winner is the first i in E searching ptr, ptr+1, ... modulo NREQ.
- On a rising edge with E non-empty and winner w:
  - `gnt` <= one-hot(w).
  - `ld_data` <= `req_data`[w].
  - If `req_addr`[w] < NREG: `ld` <= one-hot(`req_addr`[w]) and `err` <= 0.
  - Otherwise: `ld` <= 0 and `err` <= 1. The request is still acknowledged and consumed.
  - `ptr` <= (w+1) mod NREQ.
- On a rising edge with E empty: `gnt`, `ld` and `err` <= 0; `ptr` and `ld_data` hold.
- `busy` <= (E non-empty), registered each edge.
- Invariants:
  - At most one bit of `gnt` is high per cycle.
  - At most one bit of `ld` is high per cycle.
  - `ld` is non-zero only when `gnt` is non-zero.
  - `err` is high only when `gnt` is non-zero.
- Reset (`rst_n` low, asynchronous, any cycle): `gnt`=0, `ld`=0, `ld_data`=0, `err`=0, `busy`=0, `ptr`=0. A grant pulse in flight is cancelled. Requests still high at release are arbitrated from `ptr`=0 on the first edge after release.

## Timing
- Latency: request sampled at edge N → `gnt`, `ld` and `ld_data` valid from edge N to edge N+1. The target regN captures `ld_data` at edge N+1, so `q` updates 2 edges after the request was sampled.
- Requester protocol:
  - Hold `req`, `req_addr` and `req_data` stable until `gnt` is seen high.
  - Drop `req`, or change data, at or after the edge that ends the `gnt` cycle.
- Single active requester throughput: one grant every 2 cycles.
- Multiple active requesters: one grant per cycle, in rotating order.
- Fairness: any continuously requesting unit is granted within NREQ grants (within 2*NREQ cycles worst case).
- `req` rising in the same cycle that its own `gnt` is high: ignored that cycle, eligible the next.

## Test plan
- Reset values: assert `rst_n`=0 mid-run with `gnt`=4'b0010 high → all outputs 0 immediately, without waiting for an edge. After release with `req`=4'b1010, the first grant goes to requester 1 (`ptr`=0).
- Single write: `req`=4'b0001, addr0=2, data0=8'h03 → next cycle `gnt`=4'b0001, `ld`=4'b0100, `ld_data`=8'h03. The attached regN 2 reads 8'h03 one edge later. Holding `req` for 2 cycles yields exactly one grant.
- Round-robin: all four requesting continuously with distinct addresses and data 8'h10..8'h13 → grant order 0,1,2,3,0 on consecutive cycles. Each `ld` is one-hot matching that requester's address, and `ld_data` matches its data.
- Pointer rotation: grant 2 alone, then `req`=4'b0011 → requester 0 granted before 1, because the search starts at `ptr`=3.
- Same-register contention: requesters 1 and 3 both target register 0 with 8'h0F and 8'hF0 → two consecutive `ld`=4'b0001 pulses carrying 8'h0F then 8'hF0; the register finally holds 8'hF0.
- Out-of-range index: NREG=3, addr=3 → `gnt` pulses, `ld`=0, `err`=1 for exactly one cycle. No register changes.
